prog_loader: RTL and testbench

- Initiator side of the core's program-load port: assembles a byte stream into 32-bit instruction words.
- Drives the core's mem_in / mem_adr / instr_en inputs, one memory write per word.
- Holds the core in reset while loading and releases it once the whole image is written.
- Sits between a byte source (UART receiver, test harness) and the processor shell.

---
 rtl/prog_loader.sv | 172 +++++++++++++++++
 tb/tb_prog_loader.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// prog_loader: turns a big-endian byte stream (2-byte word count, then
// 4-byte words) into one core-memory write per word, keeping the core in
// reset until the whole image has been written.
module prog_loader #(
    parameter logic [31:0] BASE_ADR  = 32'd0,
    parameter logic [31:0] ADR_STEP  = 32'd1,
    parameter logic [15:0] MAX_WORDS = 16'd256
) (
    input  logic        clk,
    input  logic        res,
    input  logic        start,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic [31:0] mem_in,
    output logic [31:0] mem_adr,
    output logic        instr_en,
    output logic        core_res_n,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        DATA,
        WRITE,
        DONE,
        ERR
    } state_t;

    state_t      state;
    state_t      next_state;

    logic        hdr_second;
    logic [1:0]  byte_cnt;
    logic [23:0] asm_word;
    logic [15:0] idx;
    logic [15:0] word_cnt;

    logic        accept;
    logic        launch;
    logic [15:0] hdr_count;

    logic        byte_ready_d;
    logic        instr_en_d;
    logic        core_res_n_d;
    logic        busy_d;
    logic        done_d;
    logic        err_d;

    // byte_ready is registered and is only ever high in HDR and DATA,
    // so the handshake alone tells us a byte is being consumed.
    assign accept    = byte_valid && byte_ready;
    assign launch    = start && (state == IDLE || state == DONE || state == ERR);
    assign hdr_count = {word_cnt[15:8], byte_in};

    // State register.
    always_ff @(posedge clk) begin
        if (!res) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: header decode, 4-byte assembly, one-cycle write.
    always_comb begin
        next_state = state;
        case (state)
            IDLE, DONE, ERR: begin
                if (start) begin
                    next_state = HDR;
                end
            end
            HDR: begin
                if (accept && hdr_second) begin
                    if (hdr_count == 16'd0) begin
                        next_state = DONE;
                    end else if (hdr_count > MAX_WORDS) begin
                        next_state = ERR;
                    end else begin
                        next_state = DATA;
                    end
                end
            end
            DATA: begin
                if (accept && byte_cnt == 2'd3) begin
                    next_state = WRITE;
                end
            end
            WRITE: begin
                if (idx + 16'd1 == word_cnt) begin
                    next_state = DONE;
                end else begin
                    next_state = DATA;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Output decode from the upcoming state so every output leaves a flop.
    always_comb begin
        byte_ready_d = (next_state == HDR) || (next_state == DATA);
        instr_en_d   = (next_state == WRITE);
        core_res_n_d = (next_state == DONE);
        busy_d       = (next_state == HDR) || (next_state == DATA) || (next_state == WRITE);
        done_d       = (next_state == DONE);
        err_d        = (next_state == ERR);
    end

    // Registered control outputs.
    always_ff @(posedge clk) begin
        if (!res) begin
            byte_ready <= 1'b0;
            instr_en   <= 1'b0;
            core_res_n <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            byte_ready <= byte_ready_d;
            instr_en   <= instr_en_d;
            core_res_n <= core_res_n_d;
            busy       <= busy_d;
            done       <= done_d;
            err        <= err_d;
        end
    end

    // Datapath: header count, word assembly, write address/data and index.
    always_ff @(posedge clk) begin
        if (!res) begin
            hdr_second <= 1'b0;
            byte_cnt   <= 2'd0;
            asm_word   <= 24'd0;
            idx        <= 16'd0;
            word_cnt   <= 16'd0;
            mem_in     <= 32'd0;
            mem_adr    <= 32'd0;
        end else begin
            if (launch) begin
                hdr_second <= 1'b0;
                byte_cnt   <= 2'd0;
                idx        <= 16'd0;
                word_cnt   <= 16'd0;
            end
            if (state == HDR && accept) begin
                if (!hdr_second) begin
                    word_cnt[15:8] <= byte_in;
                    hdr_second     <= 1'b1;
                end else begin
                    word_cnt[7:0]  <= byte_in;
                end
            end
            if (state == DATA && accept) begin
                asm_word <= {asm_word[15:0], byte_in};
                byte_cnt <= byte_cnt + 2'd1;
                if (byte_cnt == 2'd3) begin
                    mem_in  <= {asm_word, byte_in};
                    mem_adr <= BASE_ADR + (32'(idx) * ADR_STEP);
                end
            end
            if (state == WRITE) begin
                idx <= idx + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: drives two loaders (default addressing and BASE_ADR=0x10,
// ADR_STEP=4) with the same byte streams and compares every output each
// cycle against a byte-list model of the load protocol.
module tb_prog_loader;

    logic        clk        = 1'b0;
    logic        res        = 1'b0;
    logic        start      = 1'b0;
    logic [7:0]  byte_in    = 8'd0;
    logic        byte_valid = 1'b0;

    logic        byte_ready_a, instr_en_a, core_res_n_a, busy_a, done_a, err_a;
    logic [31:0] mem_in_a, mem_adr_a;
    logic        byte_ready_b, instr_en_b, core_res_n_b, busy_b, done_b, err_b;
    logic [31:0] mem_in_b, mem_adr_b;

    prog_loader dut_a (
        .clk(clk), .res(res), .start(start), .byte_in(byte_in), .byte_valid(byte_valid),
        .byte_ready(byte_ready_a), .mem_in(mem_in_a), .mem_adr(mem_adr_a),
        .instr_en(instr_en_a), .core_res_n(core_res_n_a), .busy(busy_a),
        .done(done_a), .err(err_a)
    );

    prog_loader #(.BASE_ADR(32'h10), .ADR_STEP(32'd4)) dut_b (
        .clk(clk), .res(res), .start(start), .byte_in(byte_in), .byte_valid(byte_valid),
        .byte_ready(byte_ready_b), .mem_in(mem_in_b), .mem_adr(mem_adr_b),
        .instr_en(instr_en_b), .core_res_n(core_res_n_b), .busy(busy_b),
        .done(done_b), .err(err_b)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Model: the phase of the load plus the list of bytes taken so far.
    typedef enum {M_IDLE, M_LOAD, M_WRITE, M_DONE, M_ERR} mphase_t;
    mphase_t     m_phase = M_IDLE;
    logic [7:0]  m_bytes [0:1100];
    int          m_nb = 0;
    int          m_n = 0;
    int          m_wrote = 0;
    logic [31:0] m_in = 32'd0;
    logic [31:0] m_adr_a = 32'd0;
    logic [31:0] m_adr_b = 32'd0;
    bit          model_valid = 1'b0;

    // Model update at every rising edge from the inputs held across it.
    initial begin
        forever begin
            @(posedge clk);
            if (!res) begin
                m_phase = M_IDLE; m_nb = 0; m_n = 0; m_wrote = 0;
                m_in = 32'd0; m_adr_a = 32'd0; m_adr_b = 32'd0;
            end else begin
                case (m_phase)
                    M_IDLE, M_DONE, M_ERR: begin
                        if (start) begin
                            m_phase = M_LOAD; m_nb = 0; m_wrote = 0;
                        end
                    end
                    M_LOAD: begin
                        if (byte_valid && m_nb < 1100) begin
                            m_bytes[m_nb] = byte_in;
                            m_nb++;
                            if (m_nb == 2) begin
                                m_n = int'(m_bytes[0]) * 256 + int'(m_bytes[1]);
                                if (m_n == 0) m_phase = M_DONE;
                                else if (m_n > 256) m_phase = M_ERR;
                            end else if (m_nb > 2 && (m_nb - 2) % 4 == 0) begin
                                m_in    = {m_bytes[m_nb-4], m_bytes[m_nb-3],
                                           m_bytes[m_nb-2], m_bytes[m_nb-1]};
                                m_adr_a = 32'(m_wrote);
                                m_adr_b = 32'h10 + 32'(m_wrote) * 32'd4;
                                m_phase = M_WRITE;
                            end
                        end
                    end
                    M_WRITE: begin
                        m_wrote++;
                        m_phase = (m_wrote == m_n) ? M_DONE : M_LOAD;
                    end
                    default: m_phase = M_IDLE;
                endcase
            end
            model_valid = 1'b1;
        end
    end

    logic [31:0] wr_in    [0:1023];
    logic [31:0] wr_adr_a [0:1023];
    logic [31:0] wr_adr_b [0:1023];
    int          nw = 0;

    // Per-cycle comparison on the falling edge, plus a log of write strobes.
    initial begin
        forever begin
            @(negedge clk);
            if (model_valid) begin
                checkOutput("byte_ready_a", byte_ready_a, (m_phase == M_LOAD));
                checkOutput("instr_en_a",   instr_en_a,   (m_phase == M_WRITE));
                checkOutput("core_res_n_a", core_res_n_a, (m_phase == M_DONE));
                checkOutput("busy_a",       busy_a,       (m_phase == M_LOAD || m_phase == M_WRITE));
                checkOutput("done_a",       done_a,       (m_phase == M_DONE));
                checkOutput("err_a",        err_a,        (m_phase == M_ERR));
                checkOutput("mem_in_a",     mem_in_a,     m_in);
                checkOutput("mem_adr_a",    mem_adr_a,    m_adr_a);
                checkOutput("byte_ready_b", byte_ready_b, (m_phase == M_LOAD));
                checkOutput("instr_en_b",   instr_en_b,   (m_phase == M_WRITE));
                checkOutput("core_res_n_b", core_res_n_b, (m_phase == M_DONE));
                checkOutput("done_b",       done_b,       (m_phase == M_DONE));
                checkOutput("err_b",        err_b,        (m_phase == M_ERR));
                checkOutput("mem_in_b",     mem_in_b,     m_in);
                checkOutput("mem_adr_b",    mem_adr_b,    m_adr_b);
                if (instr_en_a && nw < 1024) begin
                    wr_in[nw]    = mem_in_a;
                    wr_adr_a[nw] = mem_adr_a;
                    wr_adr_b[nw] = mem_adr_b;
                    nw++;
                end
            end
        end
    end

    logic [7:0] stream [0:1100];
    int         stream_len = 0;

    task automatic applyStimulus(input logic r, input logic s, input logic bv,
                                 input logic [7:0] b);
        @(negedge clk);
        res        = r;
        start      = s;
        byte_valid = bv;
        byte_in    = b;
    endtask

    task automatic startLoad();
        applyStimulus(1'b1, 1'b1, 1'b0, 8'd0);
    endtask

    task automatic sendStream(input int gap_pct, input bit poke_start);
        int  i   = 0;
        int  cyc = 0;
        bit  bv;
        bit  st;
        while (i < stream_len && cyc < 20 * stream_len + 50) begin
            bv = ($urandom_range(99) >= gap_pct);
            st = poke_start && ($urandom_range(9) == 0);
            applyStimulus(1'b1, st, bv, bv ? stream[i] : 8'($urandom));
            if (bv && byte_ready_a) i++;
            cyc++;
        end
        checkOutput("stream_consumed", 32'(i), 32'(stream_len));
    endtask

    task automatic finishLoad();
        int k = 0;
        do begin
            applyStimulus(1'b1, 1'b0, 1'($urandom_range(1)), 8'($urandom));
            k++;
        end while (!(done_a || err_a) && k < 40);
        checkOutput("load_finished", 32'(done_a || err_a), 32'd1);
    endtask

    task automatic setBasic();
        stream[0] = 8'h00; stream[1] = 8'h02;
        stream[2] = 8'h20; stream[3] = 8'h08; stream[4] = 8'h00; stream[5] = 8'h05;
        stream[6] = 8'hAC; stream[7] = 8'h08; stream[8] = 8'h00; stream[9] = 8'h04;
        stream_len = 10;
    endtask

    task automatic basicLoad(input int gap_pct, input string tag);
        int p0;
        p0 = nw;
        startLoad();
        setBasic();
        sendStream(gap_pct, 1'b1);
        finishLoad();
        checkOutput({tag, "_pulses"}, 32'(nw - p0), 32'd2);
        checkOutput({tag, "_in0"},    wr_in[p0],        32'h20080005);
        checkOutput({tag, "_adr0"},   wr_adr_a[p0],     32'h0);
        checkOutput({tag, "_adr0_b"}, wr_adr_b[p0],     32'h10);
        checkOutput({tag, "_in1"},    wr_in[p0+1],      32'hAC080004);
        checkOutput({tag, "_adr1"},   wr_adr_a[p0+1],   32'h1);
        checkOutput({tag, "_adr1_b"}, wr_adr_b[p0+1],   32'h14);
        checkOutput({tag, "_done"},   32'(done_a),      32'd1);
        checkOutput({tag, "_core"},   32'(core_res_n_a), 32'd1);
    endtask

    // Scenario sequence.
    initial begin
        int p0;
        int n;
        int exp_w;

        // Reset and idle behaviour.
        applyStimulus(1'b0, 1'b0, 1'b1, 8'hAA);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'hAA);
        repeat (3) applyStimulus(1'b1, 1'b0, 1'b1, 8'hAA);
        checkOutput("idle_ready", 32'(byte_ready_a), 32'd0);
        checkOutput("idle_busy",  32'(busy_a),       32'd0);
        checkOutput("idle_core",  32'(core_res_n_a), 32'd0);
        checkOutput("idle_in",    mem_in_a,          32'd0);

        // Basic load, then with gaps and backpressure.
        basicLoad(0,  "basic");
        basicLoad(50, "gaps");

        // Zero-length image.
        p0 = nw;
        startLoad();
        stream[0] = 8'h00; stream[1] = 8'h00; stream_len = 2;
        sendStream(0, 1'b0);
        finishLoad();
        checkOutput("zero_pulses", 32'(nw - p0), 32'd0);
        checkOutput("zero_done",   32'(done_a),  32'd1);

        // Oversized header.
        p0 = nw;
        startLoad();
        stream[0] = 8'h01; stream[1] = 8'h01; stream_len = 2;
        sendStream(0, 1'b0);
        finishLoad();
        checkOutput("over_pulses", 32'(nw - p0), 32'd0);
        checkOutput("over_err",    32'(err_a),   32'd1);
        checkOutput("over_core",   32'(core_res_n_a), 32'd0);

        // Largest legal image.
        p0 = nw;
        startLoad();
        stream[0] = 8'h01; stream[1] = 8'h00;
        for (int i = 2; i < 1026; i++) stream[i] = 8'($urandom);
        stream_len = 1026;
        sendStream(20, 1'b1);
        finishLoad();
        checkOutput("max_pulses",  32'(nw - p0), 32'd256);
        checkOutput("max_last_a",  wr_adr_a[nw-1], 32'd255);
        checkOutput("max_last_b",  wr_adr_b[nw-1], 32'h40C);
        checkOutput("max_done",    32'(done_a), 32'd1);

        // Reset after the third byte of the first word.
        p0 = nw;
        startLoad();
        stream[0] = 8'h00; stream[1] = 8'h02;
        stream[2] = 8'h11; stream[3] = 8'h22; stream[4] = 8'h33; stream_len = 5;
        sendStream(30, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h44);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
        checkOutput("rst_pulses", 32'(nw - p0), 32'd0);
        checkOutput("rst_busy",   32'(busy_a),  32'd0);
        checkOutput("rst_in",     mem_in_a,     32'd0);
        checkOutput("rst_adr_b",  mem_adr_b,    32'd0);
        basicLoad(0, "after_rst");

        // Reload from DONE: core goes back into reset at the start edge.
        p0 = nw;
        startLoad();
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
        checkOutput("reload_core", 32'(core_res_n_a), 32'd0);
        checkOutput("reload_done", 32'(done_a),       32'd0);
        stream[0] = 8'h00; stream[1] = 8'h01;
        stream[2] = 8'hDE; stream[3] = 8'hAD; stream[4] = 8'hBE; stream[5] = 8'hEF;
        stream_len = 6;
        sendStream(25, 1'b1);
        finishLoad();
        checkOutput("reload_pulses", 32'(nw - p0), 32'd1);
        checkOutput("reload_in",     wr_in[p0],    32'hDEADBEEF);
        checkOutput("reload_adr",    wr_adr_a[p0], 32'd0);
        checkOutput("reload_done2",  32'(done_a),  32'd1);

        // Random images, one of them oversized.
        for (int it = 0; it < 6; it++) begin
            n = (it == 3) ? 300 : int'($urandom_range(5));
            exp_w = (n <= 256) ? n : 0;
            p0 = nw;
            startLoad();
            stream[0] = 8'(n >> 8);
            stream[1] = 8'(n);
            stream_len = (n <= 256) ? 2 + 4 * n : 2;
            for (int i = 2; i < stream_len; i++) stream[i] = 8'($urandom);
            sendStream(int'($urandom_range(60)), 1'b1);
            finishLoad();
            checkOutput("rand_pulses", 32'(nw - p0), 32'(exp_w));
        end

        repeat (3) applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
